// File: rtl/aes_pkg.sv
// Definitions shared by the AES engine and its input/output stages.
// Holds the block geometry, byte-ordering helper and command encodings.
package aes_pkg;

   localparam int AES_NBYTES  = 16;
   localparam int AES_BLOCK_W = 128;

   typedef enum logic [1:0] {
      C_ID = 2'b00,
      C_SP = 2'b01,
      C_SK = 2'b10,
      C_ST = 2'b11
   } aes_cmd_e;

   // Byte 0 is the most significant byte of the block.
   function automatic logic [7:0] aes_byte(input logic [AES_BLOCK_W-1:0] block,
                                           input int unsigned i);
      return block[AES_BLOCK_W-1-8*i -: 8];
   endfunction

endpackage

// File: rtl/aes_output_interface.sv
// Byte-serial ciphertext output stage: captures a block from the core, hands it
// out one byte per rd, then zeroizes and pulses read_done for one cycle.
module aes_output_interface
   import aes_pkg::*;
#(
   parameter int NBYTES = AES_NBYTES,
   parameter int DW     = 8
) (
   input  logic                      clk,
   input  logic                      rst_,
   input  logic [NBYTES*DW-1:0]      ct_in,
   input  logic                      ct_valid,
   output logic                      ct_accept,
   input  logic                      rd,
   input  logic                      clr,
   output logic [DW-1:0]             dout,
   output logic [$clog2(NBYTES)-1:0] byte_idx,
   output logic                      data_ok,
   output logic                      read_done,
   output logic                      overrun
);

   localparam int BW = NBYTES * DW;
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DONE
   } state_e;

   state_e          state_reg,   state_next;
   logic [BW-1:0]   buffer_reg,  buffer_next;
   logic [IW-1:0]   idx_reg,     idx_next;
   logic [DW-1:0]   dout_reg,    dout_next;
   logic            overrun_reg, overrun_next;

   logic [DW-1:0]   block_bytes [NBYTES];
   logic [IW-1:0]   idx_inc;

   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
         assign block_bytes[gi] = buffer_reg[BW-1-gi*DW -: DW];
      end
   endgenerate

   assign idx_inc = idx_reg + 1'b1;

   always_comb begin
      state_next   = state_reg;
      buffer_next  = buffer_reg;
      idx_next     = idx_reg;
      dout_next    = dout_reg;
      overrun_next = overrun_reg;

      case (state_reg)
         S_IDLE: begin
            if (ct_valid) begin
               buffer_next = ct_in;
               dout_next   = ct_in[BW-1 -: DW];
               idx_next    = '0;
               state_next  = S_SEND;
            end
         end
         S_SEND: begin
            if (ct_valid) overrun_next = 1'b1;
            if (rd) begin
               if (idx_reg == LAST_IDX) begin
                  // Zeroize on the way into DONE so the pulse cycle already shows a clean bus.
                  state_next  = S_DONE;
                  buffer_next = '0;
                  dout_next   = '0;
                  idx_next    = '0;
               end else begin
                  idx_next  = idx_inc;
                  dout_next = block_bytes[idx_inc];
               end
            end
         end
         S_DONE: begin
            if (ct_valid) overrun_next = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      if (clr) begin
         state_next   = S_IDLE;
         buffer_next  = '0;
         dout_next    = '0;
         idx_next     = '0;
         overrun_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_reg   <= S_IDLE;
         buffer_reg  <= '0;
         idx_reg     <= '0;
         dout_reg    <= '0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         buffer_reg  <= buffer_next;
         idx_reg     <= idx_next;
         dout_reg    <= dout_next;
         overrun_reg <= overrun_next;
      end
   end

   assign ct_accept = (state_reg == S_IDLE);
   assign data_ok   = (state_reg == S_SEND);
   assign read_done = (state_reg == S_DONE);
   assign dout      = dout_reg;
   assign byte_idx  = idx_reg;
   assign overrun   = overrun_reg;

endmodule

// File: tb/tb_aes_output_interface.sv
// Bench for aes_output_interface: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the output stage.
module tb_aes_output_interface;

   logic         clk = 1'b0;
   logic         rst_;
   logic [127:0] ct_in;
   logic         ct_valid;
   logic         ct_accept;
   logic         rd;
   logic         clr;
   logic [7:0]   dout;
   logic [3:0]   byte_idx;
   logic         data_ok;
   logic         read_done;
   logic         overrun;

   int checks = 0;
   int errors = 0;

   // Model: bytes still to be read, a pending done pulse, sticky overrun.
   logic [7:0] m_q[$];
   bit         m_done;
   bit         m_ovr;

   aes_output_interface #(.NBYTES(16), .DW(8)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .ct_in     (ct_in),
      .ct_valid  (ct_valid),
      .ct_accept (ct_accept),
      .rd        (rd),
      .clr       (clr),
      .dout      (dout),
      .byte_idx  (byte_idx),
      .data_ok   (data_ok),
      .read_done (read_done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_done = 1'b0;
      m_ovr  = 1'b0;
   endtask

   task automatic model_edge(input bit r, input bit v, input bit c, input logic [127:0] ct);
      if (c) begin
         model_reset();
      end else if (m_q.size() > 0) begin
         if (v) m_ovr = 1'b1;
         if (r) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_done = 1'b1;
         end
      end else if (m_done) begin
         if (v) m_ovr = 1'b1;
         m_done = 1'b0;
      end else if (v) begin
         for (int i = 0; i < 16; i++) m_q.push_back(ct[127-8*i -: 8]);
      end
   endtask

   task automatic check_outputs(input string tag);
      bit busy;
      busy = (m_q.size() > 0);
      check_val({tag, ".data_ok"},   32'(data_ok),   32'(busy));
      check_val({tag, ".dout"},      32'(dout),      busy ? 32'(m_q[0]) : 32'h0);
      check_val({tag, ".byte_idx"},  32'(byte_idx),  busy ? 32'(16 - m_q.size()) : 32'h0);
      check_val({tag, ".read_done"}, 32'(read_done), 32'(m_done));
      check_val({tag, ".ct_accept"}, 32'(ct_accept), 32'(!busy && !m_done));
      check_val({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
   endtask

   task automatic step(input string tag, input bit r, input bit v, input bit c,
                       input logic [127:0] ct);
      @(negedge clk);
      rd       = r;
      ct_valid = v;
      clr      = c;
      ct_in    = ct;
      @(posedge clk);
      model_edge(r, v, c, ct);
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [127:0] rand_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic load(input string tag, input logic [127:0] ct);
      step(tag, 1'b0, 1'b1, 1'b0, ct);
   endtask

   logic [127:0] blk;
   logic [127:0] all_ones;
   int           pulses;

   initial begin
      rst_     = 1'b0;
      ct_in    = '0;
      ct_valid = 1'b0;
      rd       = 1'b0;
      clr      = 1'b0;
      all_ones = '1;
      model_reset();

      // 1. reset then idle
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_ = 1'b1;
      step("idle", 1'b0, 1'b0, 1'b0, '0);
      $display("test reset: checks=%0d errors=%0d", checks, errors);

      // 2. full back-to-back read of the known vector
      blk = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      load("full_load", blk);
      check_val("full_first_byte", 32'(dout), 32'h69);
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         step("full_rd", 1'b1, 1'b0, 1'b0, '0);
         if (read_done) pulses++;
      end
      check_val("full_last_data_ok", 32'(data_ok), 32'h0);
      step("full_after", 1'b0, 1'b0, 1'b0, '0);
      check_val("full_accept", 32'(ct_accept), 32'h1);
      check_val("full_pulses", 32'(pulses), 32'h1);
      $display("test full read: checks=%0d errors=%0d", checks, errors);

      // 3. throttled read, rd every third cycle
      load("thr_load", rand_block());
      for (int i = 0; i < 48; i++)
         step("thr", (i % 3) == 2, 1'b0, 1'b0, '0);
      repeat (2) step("thr_tail", 1'b0, 1'b0, 1'b0, '0);
      $display("test throttled read: checks=%0d errors=%0d", checks, errors);

      // 4. overrun at byte_idx 5, then finish the block
      load("ovr_load", rand_block());
      repeat (5) step("ovr_rd", 1'b1, 1'b0, 1'b0, '0);
      check_val("ovr_idx5", 32'(byte_idx), 32'd5);
      step("ovr_hit", 1'b0, 1'b1, 1'b0, all_ones);
      check_val("ovr_flag", 32'(overrun), 32'h1);
      repeat (12) step("ovr_rd2", 1'b1, 1'b0, 1'b0, '0);
      repeat (3) step("ovr_tail", 1'b0, 1'b0, 1'b0, '0);
      check_val("ovr_sticky", 32'(overrun), 32'h1);
      $display("test overrun: checks=%0d errors=%0d", checks, errors);

      // 5. clr at byte_idx 7, then a fresh block
      load("clr_load", rand_block());
      repeat (7) step("clr_rd", 1'b1, 1'b0, 1'b0, '0);
      step("clr_hit", 1'b1, 1'b1, 1'b1, rand_block());
      check_val("clr_data_ok", 32'(data_ok), 32'h0);
      check_val("clr_dout", 32'(dout), 32'h0);
      repeat (3) step("clr_idle", 1'b0, 1'b0, 1'b0, '0);
      blk = rand_block();
      load("clr_reload", blk);
      check_val("clr_reload_byte0", 32'(dout), 32'(blk[127:120]));
      repeat (16) step("clr_rd2", 1'b1, 1'b0, 1'b0, '0);
      step("clr_tail", 1'b0, 1'b0, 1'b0, '0);
      $display("test clr: checks=%0d errors=%0d", checks, errors);

      // 6. async reset between edges at byte_idx 3
      load("arst_load", rand_block());
      repeat (3) step("arst_rd", 1'b0 == 1'b0, 1'b0, 1'b0, '0);
      check_val("arst_idx3", 32'(byte_idx), 32'd3);
      #2 rst_ = 1'b0;
      #1;
      check_val("arst_data_ok", 32'(data_ok), 32'h0);
      check_val("arst_dout", 32'(dout), 32'h0);
      model_reset();
      @(negedge clk);
      rd = 1'b0;
      rst_ = 1'b1;
      blk = rand_block();
      load("arst_reload", blk);
      check_val("arst_byte0", 32'(dout), 32'(blk[127:120]));
      repeat (16) step("arst_rd2", 1'b1, 1'b0, 1'b0, '0);
      step("arst_tail", 1'b0, 1'b0, 1'b0, '0);
      $display("test async reset: checks=%0d errors=%0d", checks, errors);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step("rand", $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
              $urandom_range(0, 49) == 0, rand_block());
      end
      $display("test random: checks=%0d errors=%0d", checks, errors);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_output_interface.md
Name: aes_output_interface

Overview:
Byte-serial ciphertext output stage directly downstream of aes_engine. It captures the 128-bit ciphertext block when the core signals completion, then presents the block one byte per read handshake on an 8-bit bus, holding data_ok high until all bytes are read. After the read finishes it clears its buffer and notifies the core with a one-cycle pulse, allowing the core to drop its own data_ok and accept a new command.

Parameters:
NBYTES, 16, number of bytes per block; the counter width is derived from it.
DW, 8, output byte width; the block width is NBYTES*DW.

Ports:
clk  input  1  system clock, rising-edge active
rst_  input  1  asynchronous active-low reset
ct_in  input  NBYTES*DW  ciphertext from the core; byte 0 = ct_in[127:120]
ct_valid  input  1  one-cycle strobe from the core; ct_in is valid in this cycle
ct_accept  output  1  high when the block is idle and can capture a new block
rd  input  1  host read strobe; each sampled high pops one byte
clr  input  1  synchronous abort and zeroize
dout  output  DW  current output byte
byte_idx  output  $clog2(NBYTES)  index of the byte currently on dout
data_ok  output  1  dout holds a valid unread byte
read_done  output  1  one-cycle pulse after the last byte is read
overrun  output  1  sticky error flag

Behaviour:
- Reset (rst_ low, async): state=IDLE; buffer=0, dout=0, byte_idx=0, data_ok=0, read_done=0, overrun=0, ct_accept=1 once released.
- FSM states are IDLE, SEND, DONE.
- IDLE:
  - ct_accept=1.
  - ct_valid=1 -> ct_in is latched into the buffer at this edge; next state is SEND with byte_idx=0.
  - In the first SEND cycle, data_ok=1 and dout=ct_in[127:120], giving 1-cycle latency from ct_valid.
- SEND:
  - data_ok=1, ct_accept=0, dout = buffer byte[byte_idx], driven from a register.
  - rd=1 with byte_idx<NBYTES-1 -> byte_idx increments and dout shows the next byte on the following cycle.
  - rd held high continuously reads one byte per cycle.
  - rd=1 with byte_idx=NBYTES-1 -> next state is DONE; data_ok=0 on the next cycle.
- DONE, exactly one cycle:
  - read_done=1, buffer zeroized, dout=0, byte_idx=0.
  - Next state is IDLE; ct_accept returns to 1 on the cycle after DONE.
- rd while data_ok=0 is ignored, with no flag.
- ct_valid while ct_accept=0, in SEND or DONE, is ignored; the buffer is not disturbed and overrun is set to 1.
  - This includes ct_valid in the same cycle as the final rd.
- overrun clears only on reset or clr.
- clr=1 in any state:
  - Next cycle is IDLE with the buffer zeroized, dout=0, byte_idx=0, data_ok=0, overrun=0; read_done is not pulsed.
  - clr has priority over rd and ct_valid in the same cycle.
- Async reset mid-read immediately drops data_ok and clears all state; no partial block survives.
- The byte counter never wraps past NBYTES-1; a DONE transition always occurs at the final rd.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NBYTES=16 and AES_BLOCK_W=128;
  - the byte-ordering helper (byte i = block[127-8i -: 8]);
  - the command encodings C_ID=2'b00, C_SP=2'b01, C_SK=2'b10, C_ST=2'b11 used by the core's input side.
- Output FSM state encodings are local to this block.
- No sub-module: a single module holds the FSM, the counter and the byte mux; a separate piso shifter is not justified.

Test Plan:
1. Reset then idle: rst_ low 2 cycles -> data_ok=0, dout=8'h00, ct_accept=1, overrun=0.
2. Full read: ct_valid with ct_in=128'h69c4e0d86a7b0430d8cdb78070b4c55a, then rd every cycle ->
   - dout sequence 69,c4,e0,...,c5,5a with byte_idx 0..15;
   - data_ok falls the cycle after the 16th rd;
   - read_done is a single pulse, then ct_accept=1.
3. Throttled read: rd asserted every third cycle -> dout holds each byte until rd; 16 bytes are correct and in order; no duplicates or skips.
4. Overrun: ct_valid with 128'hFFFF... during SEND at byte_idx=5 -> overrun=1; remaining bytes still come from the original block; overrun stays 1 after read_done.
5. clr mid-read: clr at byte_idx=7 -> next cycle data_ok=0, dout=0, read_done never pulses; a new ct_valid is then accepted normally.
6. Async reset mid-read: rst_ low between edges at byte_idx=3 -> data_ok drops immediately; after release a fresh block reads from byte 0.
